rgmii_tx_ddr_seq: RTL and testbench
===================================

Name: rgmii_tx_ddr_seq

Overview:
- Transmit-side sequencer that drives the RGMII output DDR flip-flops (TXD[3:0], TX_CTL, TXC).
- Converts a byte-wide GMII-style stream from the MAC into per-cycle d1/d2 pairs.
- 1000 Mb/s: one byte per clock. 10/100 Mb/s: nibble-serialises each byte and synthesises the slower TXC waveform from the 125 MHz clock.
- Sits between the MAC TX path and four instances of the generic output DDR primitive.

Parameters:
- DIV_100, 5: clk cycles per TXC period at 100 Mb/s (125 MHz / 25 MHz).
- DIV_10, 50: clk cycles per TXC period at 10 Mb/s (125 MHz / 2.5 MHz).

Ports:
- clk  in  1  single 125 MHz clock.
- rst  in  1  reset; synchronous, active-high.
- speed  in  2  link speed: 00 = 10M, 01 = 100M, 10 and 11 = 1000M.
- s_txd  in  8  transmit byte.
- s_tx_en  in  1  GMII TX_EN for s_txd.
- s_tx_er  in  1  GMII TX_ER for s_txd.
- s_ready  out  1  byte on s_* is consumed this cycle.
- txd_d1  out  4  rising-edge data to TXD DDR.
- txd_d2  out  4  falling-edge data to TXD DDR.
- txctl_d1  out  1  rising-edge TX_CTL (= tx_en).
- txctl_d2  out  1  falling-edge TX_CTL (= tx_en ^ tx_er).
- txc_d1  out  1  rising-edge TXC level.
- txc_d2  out  1  falling-edge TXC level.

Behaviour:
- Reset: all outputs 0 on the clock after rst is high, including s_ready and txc_d1/txc_d2. State LO, cnt = 0, speed_q = 1000M. Reset mid-byte abandons the byte; no partial nibble is emitted afterwards.
- All d1/d2 outputs are registered. Latency from an accepted byte to its first output cycle is 1 clk.
- speed_q: speed is sampled into speed_q only on an accept cycle (s_ready = 1). Speed changes mid-byte take effect at the next byte boundary.

1000M (speed_q = 1000M):
- s_ready = 1 every cycle after reset.
- Next cycle outputs: txd_d1 = s_txd[3:0], txd_d2 = s_txd[7:4], txctl_d1 = s_tx_en, txctl_d2 = s_tx_en ^ s_tx_er, txc_d1 = 1, txc_d2 = 0.
- The 90° TXC skew is external to this block.

10/100 (N = DIV_10 or DIV_100):
- cnt counts 0..N-1 and wraps. The FSM alternates LO -> HI -> LO, advancing on cnt == N-1.
- s_ready = 1 only when state = HI and cnt == N-1 (one cycle per 2N). The byte is captured into hold_q.
- The first byte after reset or after a switch from 1000M is accepted on the first cycle, and cnt restarts at 0.
- LO period: txd_d1 = txd_d2 = hold_q[3:0]. HI period: txd_d1 = txd_d2 = hold_q[7:4].
- txctl_d1/d2 hold the captured en and en^er for both nibbles.
- TXC at 100M by cnt: 0,1 -> (1,1); 2 -> (1,0); 3,4 -> (0,0). This gives 5 half-cycles high and 5 low.
- TXC at 10M: cnt < 25 -> (1,1), else (0,0).
- Data changes only at cnt == 0, which is the TXC rising period start.

Speed switch at a boundary:
- 10/100 -> 1000M: 1000M timing from the next cycle.
- 1000M -> 10/100: cnt = 0, state LO, new byte's low nibble on the next cycle.
- Switch 10M <-> 100M: cnt restarts at 0.

Idle: the MAC supplies s_tx_en = 0 bytes. The block never stalls the stream beyond s_ready.

Optional Feature:
- Macro: RGMII_TX_STATS_EN.
- When defined, adds:
  - input stat_clr (1);
  - output stat_bytes (32): count of accepted bytes with s_tx_en = 1;
  - output stat_err (16): count of accepted bytes with s_tx_en & s_tx_er.
- Counters saturate at all-ones. They clear on rst or stat_clr; stat_clr has priority over an increment in the same cycle.
- When undefined: the ports and counters are absent and the datapath is unchanged.

Decomposition:
- Package rgmii_pkg: SPEED_10 = 2'b00, SPEED_100 = 2'b01, SPEED_1000 = 2'b10; FSM state enum {LO, HI}; TXC pattern constants.
- One sub-module, rgmii_txc_gen: cnt, wrap pulse and txc_d1/txc_d2 from speed_q. The parent holds the FSM, hold_q and output registers.

Test Plan:
- Reset then 1000M, bytes 0x55, 0xD5, 0xA3 with en = 1 -> txd pairs (5,5), (5,D), (3,A); txctl (1,1); txc (1,0); s_ready constant 1; 1-cycle latency.
- 100M, byte 0x3C with en = 1, er = 1 -> s_ready pulse every 10 cycles; txd = C for 5 cycles then 3 for 5; txctl (1,0); txc (1,1),(1,1),(1,0),(0,0),(0,0) repeating.
- 10M, byte 0x81 -> txd = 1 for 50 cycles then 8 for 50; txc high 25 / low 25 cycles; s_ready once per 100 cycles.
- speed toggled 100M -> 1000M while in a HI period -> high nibble completes its full 5 cycles; 1000M output begins the cycle after the next s_ready.
- rst asserted at cnt == 2 of a LO period at 10M -> the next cycle shows all outputs 0. After release, the first byte is accepted immediately and starts with cnt = 0.
- RGMII_TX_STATS_EN: 10 en bytes, 3 of them with er -> stat_bytes = 10, stat_err = 3; stat_clr together with an accept -> both counters 0.

Source files
------------

// File: rtl/rgmii_pkg.sv
// Shared types and constants for the RGMII transmit sequencer.
package rgmii_pkg;

    typedef enum logic [1:0] {
        SPEED_10   = 2'b00,
        SPEED_100  = 2'b01,
        SPEED_1000 = 2'b10
    } speed_t;

    typedef enum logic {
        LO = 1'b0,
        HI = 1'b1
    } state_t;

    // {txc_d1, txc_d2} level pairs
    localparam logic [1:0] TXC_HIGH = 2'b11;
    localparam logic [1:0] TXC_FALL = 2'b10;
    localparam logic [1:0] TXC_LOW  = 2'b00;
    localparam logic [1:0] TXC_GIG  = 2'b10;

    function automatic speed_t decode_speed(input logic [1:0] s);
        case (s)
            2'b00:   return SPEED_10;
            2'b01:   return SPEED_100;
            default: return SPEED_1000;
        endcase
    endfunction

endpackage

// File: rtl/rgmii_txc_gen.sv
// TXC waveform generator: half-period counter, wrap pulse and registered
// TXC DDR levels derived from the link speed.
module rgmii_txc_gen
    import rgmii_pkg::*;
#(
    parameter int unsigned DIV_100 = 5,
    parameter int unsigned DIV_10  = 50
) (
    input  logic   clk,
    input  logic   rst,
    input  speed_t speed_q,
    input  speed_t speed_n,
    input  logic   restart,
    output logic   wrap,
    output logic   txc_d1,
    output logic   txc_d2
);

    localparam int unsigned DIV_MAX = (DIV_10 > DIV_100) ? DIV_10 : DIV_100;
    localparam int unsigned CW      = $clog2(DIV_MAX);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic [1:0]    txc_n;

    always_comb begin
        wrap = 1'b0;
        case (speed_q)
            SPEED_10:  wrap = (cnt == CW'(DIV_10 - 1));
            SPEED_100: wrap = (cnt == CW'(DIV_100 - 1));
            default:   wrap = 1'b0;
        endcase

        cnt_n = (restart || wrap) ? '0 : cnt + 1'b1;

        // TXC levels follow the counter value that will be current next cycle,
        // so they line up with the registered data outputs.
        txc_n = TXC_GIG;
        case (speed_n)
            SPEED_10: txc_n = (cnt_n < CW'(DIV_10 / 2)) ? TXC_HIGH : TXC_LOW;
            SPEED_100: begin
                if (cnt_n < CW'(DIV_100 / 2))
                    txc_n = TXC_HIGH;
                else if ((DIV_100 % 2 == 1) && (cnt_n == CW'(DIV_100 / 2)))
                    txc_n = TXC_FALL;
                else
                    txc_n = TXC_LOW;
            end
            default: txc_n = TXC_GIG;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            txc_d1 <= 1'b0;
            txc_d2 <= 1'b0;
        end else begin
            cnt              <= cnt_n;
            {txc_d1, txc_d2} <= txc_n;
        end
    end

endmodule

// File: rtl/rgmii_tx_ddr_seq.sv
// RGMII transmit DDR sequencer (1000M byte / 10-100M nibble).
// Optional byte/error counters are built when RGMII_TX_STATS_EN is defined.
module rgmii_tx_ddr_seq
    import rgmii_pkg::*;
#(
    parameter int unsigned DIV_100 = 5,
    parameter int unsigned DIV_10  = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] speed,
    input  logic [7:0] s_txd,
    input  logic       s_tx_en,
    input  logic       s_tx_er,
    output logic       s_ready,
    output logic [3:0] txd_d1,
    output logic [3:0] txd_d2,
    output logic       txctl_d1,
    output logic       txctl_d2,
    output logic       txc_d1,
    output logic       txc_d2
`ifdef RGMII_TX_STATS_EN
    ,
    input  logic        stat_clr,
    output logic [31:0] stat_bytes,
    output logic [15:0] stat_err
`endif
);

    state_t     state, state_n;
    speed_t     speed_q, speed_n;
    logic [7:0] hold_d, d_n;
    logic       hold_en, hold_er, en_n, er_n;
    logic       wrap;
    logic [3:0] nib_lo_n, nib_hi_n;

    // At 1000M every cycle is a byte boundary, which also makes the first
    // byte after reset or after a drop from 1000M accepted at once.
    assign s_ready = !rst && ((speed_q == SPEED_1000) || (state == HI && wrap));

    rgmii_txc_gen #(
        .DIV_100 (DIV_100),
        .DIV_10  (DIV_10)
    ) u_txc_gen (
        .clk     (clk),
        .rst     (rst),
        .speed_q (speed_q),
        .speed_n (speed_n),
        .restart (s_ready),
        .wrap    (wrap),
        .txc_d1  (txc_d1),
        .txc_d2  (txc_d2)
    );

    always_comb begin
        speed_n = speed_q;
        state_n = state;
        d_n     = hold_d;
        en_n    = hold_en;
        er_n    = hold_er;
        if (s_ready) begin
            speed_n = decode_speed(speed);
            state_n = LO;
            d_n     = s_txd;
            en_n    = s_tx_en;
            er_n    = s_tx_er;
        end else if (wrap) begin
            state_n = HI;
        end

        if (speed_n == SPEED_1000) begin
            nib_lo_n = d_n[3:0];
            nib_hi_n = d_n[7:4];
        end else begin
            nib_lo_n = (state_n == LO) ? d_n[3:0] : d_n[7:4];
            nib_hi_n = nib_lo_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= LO;
            speed_q  <= SPEED_1000;
            hold_d   <= '0;
            hold_en  <= 1'b0;
            hold_er  <= 1'b0;
            txd_d1   <= '0;
            txd_d2   <= '0;
            txctl_d1 <= 1'b0;
            txctl_d2 <= 1'b0;
        end else begin
            state    <= state_n;
            speed_q  <= speed_n;
            hold_d   <= d_n;
            hold_en  <= en_n;
            hold_er  <= er_n;
            txd_d1   <= nib_lo_n;
            txd_d2   <= nib_hi_n;
            txctl_d1 <= en_n;
            txctl_d2 <= en_n ^ er_n;
        end
    end

`ifdef RGMII_TX_STATS_EN
    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            stat_bytes <= '0;
            stat_err   <= '0;
        end else if (s_ready && s_tx_en) begin
            if (stat_bytes != '1)
                stat_bytes <= stat_bytes + 1'b1;
            if (s_tx_er && (stat_err != '1))
                stat_err <= stat_err + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_rgmii_tx_ddr_seq.sv
// Directed bench for rgmii_tx_ddr_seq; stats checks when RGMII_TX_STATS_EN is defined.
module tb_rgmii_tx_ddr_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] speed = 2'b10;
    logic [7:0] s_txd = 8'h00;
    logic       s_tx_en = 1'b0;
    logic       s_tx_er = 1'b0;
    logic       s_ready;
    logic [3:0] txd_d1, txd_d2;
    logic       txctl_d1, txctl_d2, txc_d1, txc_d2;
`ifdef RGMII_TX_STATS_EN
    logic        stat_clr = 1'b0;
    logic [31:0] stat_bytes;
    logic [15:0] stat_err;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    logic [12:0] vec;
    logic [7:0]  gbytes [3];

    always #4 clk = ~clk;

    rgmii_tx_ddr_seq #(
        .DIV_100 (5),
        .DIV_10  (50)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .speed    (speed),
        .s_txd    (s_txd),
        .s_tx_en  (s_tx_en),
        .s_tx_er  (s_tx_er),
        .s_ready  (s_ready),
        .txd_d1   (txd_d1),
        .txd_d2   (txd_d2),
        .txctl_d1 (txctl_d1),
        .txctl_d2 (txctl_d2),
        .txc_d1   (txc_d1),
        .txc_d2   (txc_d2)
`ifdef RGMII_TX_STATS_EN
        ,
        .stat_clr   (stat_clr),
        .stat_bytes (stat_bytes),
        .stat_err   (stat_err)
`endif
    );

    assign vec = {s_ready, txd_d1, txd_d2, txctl_d1, txctl_d2, txc_d1, txc_d2};

    function automatic logic [12:0] ev(input logic rdy, input logic [3:0] d1, input logic [3:0] d2,
                                       input logic c1, input logic c2, input logic [1:0] k);
        return {rdy, d1, d2, c1, c2, k};
    endfunction

    function automatic logic [1:0] txc100(input int c);
        if (c < 2)  return 2'b11;
        if (c == 2) return 2'b10;
        return 2'b00;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] sp, input logic [7:0] d, input logic en, input logic er);
        speed   = sp;
        s_txd   = d;
        s_tx_en = en;
        s_tx_er = er;
    endtask

    initial begin
        gbytes[0] = 8'h55;
        gbytes[1] = 8'hD5;
        gbytes[2] = 8'hA3;

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset", 32'(vec), 32'h0);
        tick;
        rst = 1'b0;

        // 1000M: one byte per clock, one cycle latency
        for (int i = 0; i < 3; i++) begin
            drive(2'b10, gbytes[i], 1'b1, 1'b0);
            @(negedge clk);
            if (i == 0)
                check("g1000_first", 32'(vec), 32'(ev(1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 2'b00)));
            else
                check($sformatf("g1000_%0d", i - 1), 32'(vec),
                      32'(ev(1'b1, gbytes[i-1][3:0], gbytes[i-1][7:4], 1'b1, 1'b1, 2'b10)));
            tick;
        end
        drive(2'b01, 8'h3C, 1'b1, 1'b1);
        @(negedge clk);
        check("g1000_2", 32'(vec), 32'(ev(1'b1, 4'h3, 4'hA, 1'b1, 1'b1, 2'b10)));
        tick;

        // 100M: byte 0x3C with error
        drive(2'b01, 8'hFF, 1'b0, 1'b0);
        for (int j = 0; j < 10; j++) begin
            if (j == 9) drive(2'b00, 8'h81, 1'b1, 1'b0);
            @(negedge clk);
            check($sformatf("m100_%0d", j), 32'(vec),
                  32'(ev(j == 9, (j < 5) ? 4'hC : 4'h3, (j < 5) ? 4'hC : 4'h3,
                         1'b1, 1'b0, txc100(j % 5))));
            tick;
        end

        // 10M: byte 0x81
        drive(2'b00, 8'hFF, 1'b0, 1'b0);
        for (int k = 0; k < 100; k++) begin
            if (k == 99) drive(2'b01, 8'h5A, 1'b1, 1'b0);
            @(negedge clk);
            check($sformatf("m10_%0d", k), 32'(vec),
                  32'(ev(k == 99, (k < 50) ? 4'h1 : 4'h8, (k < 50) ? 4'h1 : 4'h8,
                         1'b1, 1'b1, ((k % 50) < 25) ? 2'b11 : 2'b00)));
            tick;
        end

        // 100M -> 1000M requested during the HI period
        drive(2'b01, 8'hFF, 1'b0, 1'b0);
        for (int m = 0; m < 10; m++) begin
            if (m == 5) drive(2'b10, 8'hFF, 1'b0, 1'b0);
            if (m == 9) drive(2'b10, 8'h96, 1'b1, 1'b0);
            @(negedge clk);
            check($sformatf("sw_%0d", m), 32'(vec),
                  32'(ev(m == 9, (m < 5) ? 4'hA : 4'h5, (m < 5) ? 4'hA : 4'h5,
                         1'b1, 1'b1, txc100(m % 5))));
            tick;
        end
        drive(2'b00, 8'h7E, 1'b1, 1'b0);
        @(negedge clk);
        check("sw_1000", 32'(vec), 32'(ev(1'b1, 4'h6, 4'h9, 1'b1, 1'b1, 2'b10)));
        tick;

        // 10M, reset at cnt == 2 of the LO period
        drive(2'b00, 8'hFF, 1'b0, 1'b0);
        for (int n = 0; n < 3; n++) begin
            if (n == 2) rst = 1'b1;
            @(negedge clk);
            check($sformatf("pre_rst_%0d", n), 32'(vec),
                  32'(ev(1'b0, 4'hE, 4'hE, 1'b1, 1'b1, 2'b11)));
            tick;
        end
        @(negedge clk);
        check("rst_mid", 32'(vec), 32'h0);
        tick;
        rst = 1'b0;
        drive(2'b01, 8'hC3, 1'b1, 1'b0);
        @(negedge clk);
        check("rst_release", 32'(vec), 32'(ev(1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 2'b00)));
        tick;
        drive(2'b01, 8'hFF, 1'b0, 1'b0);
        for (int p = 0; p < 3; p++) begin
            @(negedge clk);
            check($sformatf("post_rst_%0d", p), 32'(vec),
                  32'(ev(1'b0, 4'h3, 4'h3, 1'b1, 1'b1, txc100(p))));
            tick;
        end

`ifdef RGMII_TX_STATS_EN
        rst = 1'b1;
        tick;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(2'b10, 8'(i), 1'b1, i < 3);
            tick;
        end
        drive(2'b10, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        check("stat_bytes", stat_bytes, 32'd10);
        check("stat_err", 32'(stat_err), 32'd3);
        tick;
        stat_clr = 1'b1;
        drive(2'b10, 8'h11, 1'b1, 1'b1);
        tick;
        stat_clr = 1'b0;
        drive(2'b10, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        check("stat_bytes_clr", stat_bytes, 32'd0);
        check("stat_err_clr", 32'(stat_err), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
